// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges the pipeline writeback stream with a
// long-latency unit stream, WB-priority with a bounded LU starvation window.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic [3:0]  starve_cnt
);

  localparam int          DATA_W = 32;
  localparam logic [3:0]  SMAX   = 4'(STARVE_MAX);

  logic              gnt_lu_p0;
  logic              gnt_wb_p0;
  logic              xfer_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] data_p0;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= SMAX) ? SMAX : cnt + 4'd1;
  endfunction

  // p0: combinational grant and winner select (zero-latency handshake)
  always_comb begin
    gnt_lu_p0 = lu_valid && (!wb_valid || (starve_cnt >= SMAX));
    gnt_wb_p0 = wb_valid && !gnt_lu_p0;
    xfer_p0   = gnt_lu_p0 || gnt_wb_p0;
    rd_p0     = gnt_lu_p0 ? lu_rd   : wb_rd;
    data_p0   = gnt_lu_p0 ? lu_data : wb_data;
  end

  assign wb_ready = !gnt_lu_p0;
  assign lu_ready = gnt_lu_p0;

  // p1: registered register-file write port and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd      <= 5'd0;
      rf_data    <= '0;
      starve_cnt <= 4'd0;
    end else begin
      rf_we <= xfer_p0 && (rd_p0 != 5'd0);
      if (xfer_p0) begin
        rf_rd   <= rd_p0;
        rf_data <= data_p0;
      end
      if (!lu_valid || gnt_lu_p0)
        starve_cnt <= 4'd0;
      else
        starve_cnt <= sat_inc(starve_cnt);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, x0 drop, starvation,
// ordering, asynchronous reset and idle behaviour with STARVE_MAX = 4.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [3:0]  starve_cnt;

  int tests  = 0;
  int failed = 0;

  regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;

    // reset state
    after_edge();
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_starve", {28'd0, starve_cnt}, 32'd0);
    chk("rst_wb_ready", {31'd0, wb_ready}, 32'd1);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WB only
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    chk("wb_ready", {31'd0, wb_ready}, 32'd1);
    chk("wb_lu_ready", {31'd0, lu_ready}, 32'd0);
    after_edge();
    chk("wb_we", {31'd0, rf_we}, 32'd1);
    chk("wb_rd", {27'd0, rf_rd}, 32'd5);
    chk("wb_data", rf_data, 32'hDEADBEEF);
    @(negedge clk);
    wb_valid = 1'b0;
    after_edge();
    chk("nox_we", {31'd0, rf_we}, 32'd0);
    chk("nox_rd_hold", {27'd0, rf_rd}, 32'd5);
    chk("nox_data_hold", rf_data, 32'hDEADBEEF);

    // x0 write dropped, handshake still completes
    @(negedge clk);
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h1234;
    #1;
    chk("x0_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("x0_wb_ready", {31'd0, wb_ready}, 32'd0);
    after_edge();
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    chk("x0_rd", {27'd0, rf_rd}, 32'd0);
    chk("x0_data", rf_data, 32'h1234);
    chk("x0_starve", {28'd0, starve_cnt}, 32'd0);

    // starvation: WB wins four times, then LU once
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h30;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hA9;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("stv_cnt", {28'd0, starve_cnt}, k);
      chk("stv_wb_ready", {31'd0, wb_ready}, 32'd1);
      chk("stv_lu_ready", {31'd0, lu_ready}, 32'd0);
      after_edge();
      chk("stv_we", {31'd0, rf_we}, 32'd1);
      chk("stv_rd", {27'd0, rf_rd}, 32'd3);
    end
    chk("stv_cnt_max", {28'd0, starve_cnt}, 32'd4);
    chk("stv_lu_win", {31'd0, lu_ready}, 32'd1);
    chk("stv_wb_block", {31'd0, wb_ready}, 32'd0);
    after_edge();
    chk("stv_lu_rd", {27'd0, rf_rd}, 32'd9);
    chk("stv_lu_data", rf_data, 32'hA9);
    chk("stv_cnt_clr", {28'd0, starve_cnt}, 32'd0);
    chk("stv_wb_regain", {31'd0, wb_ready}, 32'd1);
    after_edge();
    chk("stv_wb_again_rd", {27'd0, rf_rd}, 32'd3);
    chk("stv_cnt_again", {28'd0, starve_cnt}, 32'd1);

    // back-to-back same rd, WB then LU
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'd1;
    lu_valid = 1'b0;
    after_edge();
    chk("b2b_we1", {31'd0, rf_we}, 32'd1);
    chk("b2b_data1", rf_data, 32'd1);
    chk("b2b_cnt", {28'd0, starve_cnt}, 32'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'd2;
    after_edge();
    chk("b2b_we2", {31'd0, rf_we}, 32'd1);
    chk("b2b_rd2", {27'd0, rf_rd}, 32'd7);
    chk("b2b_data2", rf_data, 32'd2);

    // asynchronous reset mid-operation
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h55;
    lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'h66;
    after_edge();
    chk("pre_rst_we", {31'd0, rf_we}, 32'd1);
    chk("pre_rst_cnt", {28'd0, starve_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, rf_we}, 32'd0);
    chk("arst_cnt", {28'd0, starve_cnt}, 32'd0);
    chk("arst_rd", {27'd0, rf_rd}, 32'd0);
    chk("arst_data", rf_data, 32'd0);
    chk("arst_wb_ready", {31'd0, wb_ready}, 32'd1);
    after_edge();
    chk("arst_hold_we", {31'd0, rf_we}, 32'd0);
    chk("arst_hold_rd", {27'd0, rf_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_valid = 1'b0;
    #1;
    chk("post_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    after_edge();
    chk("post_rst_we", {31'd0, rf_we}, 32'd1);
    chk("post_rst_rd", {27'd0, rf_rd}, 32'd11);
    chk("post_rst_data", rf_data, 32'h66);

    // idle
    @(negedge clk);
    lu_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      after_edge();
      chk("idle_we", {31'd0, rf_we}, 32'd0);
      chk("idle_cnt", {28'd0, starve_cnt}, 32'd0);
      chk("idle_rd", {27'd0, rf_rd}, 32'd11);
      chk("idle_data", rf_data, 32'h66);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
